mmu_decode: RTL

MMU_DECODE -- requirements
Module: mmu_decode

---
 rtl/mmu_decode.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mmu_decode.sv
// Load-path decoder: routes loads to block RAM (one-cycle response) or MMIO (handshake),
// then aligns and extends the result. Optional MMIO timeout under MMU_DECODE_MMIO_TIMEOUT_EN.
module mmu_decode #(
    parameter int MMIO_ADDR_START_BIT = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [31:0] addr,
    input  logic [1:0]  load_size,
    input  logic        load_unsigned,
    input  logic [31:0] physical_data_out,
    output logic        mmio_req,
    output logic [31:0] mmio_addr,
    input  logic        mmio_ack,
    input  logic [31:0] mmio_rdata,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        stall,
    output logic        mmio_timeout
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RAM_RESP  = 2'd1;
    localparam logic [1:0] MMIO_WAIT = 2'd2;
    localparam logic [1:0] MMIO_DONE = 2'd3;

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] rdata_q;
    logic        capture;
    logic        is_mmio;

`ifdef MMU_DECODE_MMIO_TIMEOUT_EN
    logic [7:0]  wait_cnt;
    logic        timed_out;
`endif

    assign stall   = (state == MMIO_WAIT);
    assign capture = load_valid && !stall;
    assign is_mmio = addr[MMIO_ADDR_START_BIT];

    function automatic logic [31:0] align_extend(input logic [31:0] d, input logic [1:0] align,
                                                 input logic [1:0] size, input logic uns);
        logic [31:0] rot;
        logic [31:0] res;
        case (align)
            2'd0:    rot = d;
            2'd1:    rot = {d[7:0],  d[31:8]};
            2'd2:    rot = {d[15:0], d[31:16]};
            default: rot = {d[23:0], d[31:24]};
        endcase
        case (size)
            2'b00:   res = {{24{~uns & rot[7]}},  rot[7:0]};
            2'b01:   res = {{16{~uns & rot[15]}}, rot[15:0]};
            default: res = rot;
        endcase
        return res;
    endfunction

    // NOTE: all state here updates with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            rdata_q    <= '0;
`ifdef MMU_DECODE_MMIO_TIMEOUT_EN
            wait_cnt   <= '0;
            timed_out  <= 1'b0;
`endif
        end else begin
            case (state)
                MMIO_WAIT: begin
                    if (mmio_ack) begin
                        rdata_q <= mmio_rdata;
                        state   <= MMIO_DONE;
                    end
`ifdef MMU_DECODE_MMIO_TIMEOUT_EN
                    // Counter reads 254 during the 255th waiting cycle; an ack then still wins.
                    else if (wait_cnt == 8'd254) begin
                        rdata_q   <= '1;
                        timed_out <= 1'b1;
                        state     <= MMIO_DONE;
                    end
                    wait_cnt <= wait_cnt + 8'd1;
`endif
                end
                default: begin
                    if (capture) begin
                        addr_q     <= addr;
                        size_q     <= load_size;
                        unsigned_q <= load_unsigned;
                        state      <= is_mmio ? MMIO_WAIT : RAM_RESP;
`ifdef MMU_DECODE_MMIO_TIMEOUT_EN
                        wait_cnt   <= '0;
                        timed_out  <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // NOTE: every output gets a default first so this block never infers a latch.
    always_comb begin
        mmio_req   = 1'b0;
        mmio_addr  = '0;
        data_out   = '0;
        data_valid = 1'b0;
        case (state)
            RAM_RESP: begin
                data_valid = 1'b1;
                data_out   = align_extend(physical_data_out, addr_q[1:0], size_q, unsigned_q);
            end
            MMIO_WAIT: begin
                mmio_req  = 1'b1;
                mmio_addr = addr_q;
            end
            MMIO_DONE: begin
                data_valid = 1'b1;
                data_out   = align_extend(rdata_q, addr_q[1:0], size_q, unsigned_q);
            end
            default: ;
        endcase
    end

`ifdef MMU_DECODE_MMIO_TIMEOUT_EN
    assign mmio_timeout = (state == MMIO_DONE) && timed_out;
`else
    assign mmio_timeout = 1'b0;
`endif

endmodule
